// File: rtl/counter_seq_pkg.sv
// Shared types for the counter mode sequencer: counter mode codes, FSM states
// and the program table entry layout.
package counter_seq_pkg;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_UPDOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Must match the HITS_W the sequencer is built with for the struct to line up with cfg_data.
    localparam int ENTRY_HITS_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ADV,
        FIN
    } seq_state_t;

    typedef struct packed {
        logic                    valid;
        logic [1:0]              mode;
        logic [ENTRY_HITS_W-1:0] hits;
    } seq_entry_t;

endpackage

// File: rtl/seq_prog_table.sv
// Program table: NUM_ENTRIES x (HITS_W+3) register file with one write port
// and one asynchronous read port, fully cleared by reset.
module seq_prog_table
    import counter_seq_pkg::*;
#(
    parameter  int NUM_ENTRIES = 4,
    parameter  int HITS_W      = 4,
    localparam int AW          = $clog2(NUM_ENTRIES),
    localparam int DW          = HITS_W + 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/counter_mode_sequencer.sv
// Steps the multimode counter through a programmed list of {mode, hits} entries.
// Define SEQ_LOOP_EN to make the program wrap to entry 0 and run until aborted.
module counter_mode_sequencer
    import counter_seq_pkg::*;
#(
    parameter  int NUM_ENTRIES = 4,
    parameter  int HITS_W      = 4,
    localparam int AW          = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [HITS_W+2:0] cfg_data,
    input  logic              start,
    input  logic              abort,
    input  logic              at_limit_in,
    output logic [1:0]        mode_out,
    output logic              cnt_hold,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     step_idx
);

    localparam logic [HITS_W:0] ONE = 1;

    seq_state_t        state;
    logic [HITS_W-1:0] hit_cnt;
    logic [AW-1:0]     rd_addr;
    logic [HITS_W+2:0] rd_data;
    logic              rd_valid;
    logic [1:0]        rd_mode;
    logic [HITS_W-1:0] rd_hits;
    logic [HITS_W:0]   target;
    logic              hit_event;
    logic              target_hit;
    logic              last_entry;
`ifdef SEQ_LOOP_EN
    logic [1:0]        first_mode;
`endif

    seq_prog_table #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .HITS_W     (HITS_W)
    ) u_table (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (cfg_we && !busy),
        .waddr(cfg_addr),
        .wdata(cfg_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    assign rd_valid = rd_data[HITS_W+2];
    assign rd_mode  = rd_data[HITS_W+1:HITS_W];
    assign rd_hits  = rd_data[HITS_W-1:0];

    // The single read port looks at entry 0 when idle, the next entry during ADV,
    // and the current entry otherwise; the table is frozen while busy.
    always_comb begin
        rd_addr = step_idx;
        case (state)
            IDLE:    rd_addr = '0;
            ADV:     rd_addr = step_idx + AW'(1);
            default: rd_addr = step_idx;
        endcase

        if (rd_mode == MODE_HOLD) begin
            target = {1'b0, rd_hits} + ONE;
        end else if (rd_hits == '0) begin
            target = ONE;
        end else begin
            target = {1'b0, rd_hits};
        end

        hit_event  = (rd_mode == MODE_HOLD) || at_limit_in;
        target_hit = ({1'b0, hit_cnt} + ONE) >= target;
        last_entry = (step_idx == AW'(NUM_ENTRIES - 1)) || !rd_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            step_idx <= '0;
            hit_cnt  <= '0;
            mode_out <= MODE_HOLD;
            cnt_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SEQ_LOOP_EN
            first_mode <= MODE_HOLD;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        step_idx <= '0;
                        hit_cnt  <= '0;
                        if (rd_valid) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            mode_out <= rd_mode;
                            cnt_hold <= (rd_mode == MODE_HOLD);
`ifdef SEQ_LOOP_EN
                            first_mode <= rd_mode;
`endif
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state    <= FIN;
                        mode_out <= MODE_HOLD;
                        cnt_hold <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (hit_event) begin
                        if (target_hit) begin
                            state    <= ADV;
                            mode_out <= MODE_HOLD;
                            cnt_hold <= 1'b1;
                            hit_cnt  <= '0;
                        end else if (hit_cnt != '1) begin
                            hit_cnt <= hit_cnt + HITS_W'(1);
                        end
                    end
                end
                ADV: begin
                    if (abort) begin
                        state    <= FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (last_entry) begin
`ifdef SEQ_LOOP_EN
                        state    <= RUN;
                        step_idx <= '0;
                        mode_out <= first_mode;
                        cnt_hold <= (first_mode == MODE_HOLD);
`else
                        state    <= FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
`endif
                    end else begin
                        state    <= RUN;
                        step_idx <= step_idx + AW'(1);
                        mode_out <= rd_mode;
                        cnt_hold <= (rd_mode == MODE_HOLD);
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_mode_sequencer.sv
// Scoreboard bench for counter_mode_sequencer: scenarios push per-cycle expected
// outputs; a negedge monitor pops and compares whenever busy or done is high.
module tb_counter_mode_sequencer;
    import counter_seq_pkg::*;

    typedef struct packed {
        logic [1:0] mode;
        logic       hold;
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [6:0] cfg_data = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       at_limit_in = 1'b0;
    logic [1:0] mode_out;
    logic       cnt_hold;
    logic       busy;
    logic       done;
    logic [1:0] step_idx;

    int    checks = 0;
    int    failures = 0;
    string scenName = "reset";
    exp_t  expq[$];

    counter_mode_sequencer #(
        .NUM_ENTRIES(4),
        .HITS_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .abort      (abort),
        .at_limit_in(at_limit_in),
        .mode_out   (mode_out),
        .cnt_hold   (cnt_hold),
        .busy       (busy),
        .done       (done),
        .step_idx   (step_idx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input exp_t e);
        exp_t a;
        a = '{mode: mode_out, hold: cnt_hold, busy: busy, done: done, idx: step_idx};
        checks++;
        if (a !== e) begin
            failures++;
            $display("[TB] FAIL %s: got mode=%b hold=%b busy=%b done=%b idx=%0d, expected mode=%b hold=%b busy=%b done=%b idx=%0d",
                     name, a.mode, a.hold, a.busy, a.done, a.idx, e.mode, e.hold, e.busy, e.done, e.idx);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (busy || done)) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s unexpected: got mode=%b busy=%b done=%b idx=%0d, expected no output",
                         scenName, mode_out, busy, done, step_idx);
            end else begin
                checkOutput(scenName, expq.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic a, input logic l,
                                 input logic we, input logic [1:0] addr, input logic [6:0] data);
        start = s; abort = a; at_limit_in = l;
        cfg_we = we; cfg_addr = addr; cfg_data = data;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; at_limit_in = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 2'd0, 7'd0);
    endtask

    task automatic writeEntry(input logic [1:0] addr, input logic v, input logic [1:0] m, input logic [3:0] h);
        seq_entry_t e;
        e = '{valid: v, mode: m, hits: h};
        applyStimulus(0, 0, 0, 1, addr, e);
    endtask

    task automatic pushExp(input logic [1:0] m, input logic h, input logic b,
                           input logic d, input logic [1:0] i, input int n);
        repeat (n) expq.push_back('{mode: m, hold: h, busy: b, done: d, idx: i});
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expq.size() != 0 && n < 60) begin
            idle(1);
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s drain: %0d expected outputs never seen, required 0 pending", scenName, expq.size());
            expq.delete();
        end
        idle(3);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", '{mode: MODE_HOLD, hold: 1'b1, busy: 1'b0, done: 1'b0, idx: 2'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

`ifdef SEQ_LOOP_EN
        scenName = "loop";
        writeEntry(2'd0, 1, MODE_UP, 4'd1);
        writeEntry(2'd1, 1, MODE_DOWN, 4'd1);
        pushExp(MODE_UP,   0, 1, 0, 2'd0, 1);
        pushExp(MODE_HOLD, 1, 1, 0, 2'd0, 1);
        pushExp(MODE_DOWN, 0, 1, 0, 2'd1, 1);
        pushExp(MODE_HOLD, 1, 1, 0, 2'd1, 1);
        pushExp(MODE_UP,   0, 1, 0, 2'd0, 1);
        pushExp(MODE_HOLD, 1, 1, 0, 2'd0, 1);
        pushExp(MODE_DOWN, 0, 1, 0, 2'd1, 1);
        pushExp(MODE_HOLD, 1, 0, 1, 2'd1, 1);
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        idle(1);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        idle(1);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        idle(1);
        applyStimulus(0, 1, 0, 0, 2'd0, 7'd0);
        waitDrain();
`else
        // Single UP entry: 16 counting cycles, boundary on the last one.
        scenName = "single_up";
        writeEntry(2'd0, 1, MODE_UP, 4'd1);
        pushExp(MODE_UP,   0, 1, 0, 2'd0, 16);
        pushExp(MODE_HOLD, 1, 1, 0, 2'd0, 1);
        pushExp(MODE_HOLD, 1, 0, 1, 2'd0, 1);
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        idle(15);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        waitDrain();

        scenName = "three_entries";
        writeEntry(2'd1, 1, MODE_DOWN, 4'd1);
        writeEntry(2'd2, 1, MODE_UPDOWN, 4'd2);
        pushExp(MODE_UP,     0, 1, 0, 2'd0, 2);
        pushExp(MODE_HOLD,   1, 1, 0, 2'd0, 1);
        pushExp(MODE_DOWN,   0, 1, 0, 2'd1, 1);
        pushExp(MODE_HOLD,   1, 1, 0, 2'd1, 1);
        pushExp(MODE_UPDOWN, 0, 1, 0, 2'd2, 3);
        pushExp(MODE_HOLD,   1, 1, 0, 2'd2, 1);
        pushExp(MODE_HOLD,   1, 0, 1, 2'd2, 1);
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        idle(1);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        idle(1);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        idle(1);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        idle(1);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        waitDrain();

        // hits=0 must behave as one hit, not as an immediately met target.
        scenName = "zero_hits";
        writeEntry(2'd0, 1, MODE_DOWN, 4'd0);
        writeEntry(2'd1, 0, MODE_UP, 4'd0);
        pushExp(MODE_DOWN, 0, 1, 0, 2'd0, 2);
        pushExp(MODE_HOLD, 1, 1, 0, 2'd0, 1);
        pushExp(MODE_HOLD, 1, 0, 1, 2'd0, 1);
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        idle(1);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        waitDrain();

        scenName = "hold_entry";
        writeEntry(2'd0, 1, MODE_HOLD, 4'd3);
        pushExp(MODE_HOLD, 1, 1, 0, 2'd0, 5);
        pushExp(MODE_HOLD, 1, 0, 1, 2'd0, 1);
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        waitDrain();

        // Abort in IDLE and abort+start must both be ignored; then abort with a hit mid-run.
        scenName = "abort";
        writeEntry(2'd0, 1, MODE_UP, 4'd1);
        writeEntry(2'd1, 1, MODE_DOWN, 4'd1);
        applyStimulus(0, 1, 0, 0, 2'd0, 7'd0);
        applyStimulus(1, 1, 0, 0, 2'd0, 7'd0);
        idle(3);
        pushExp(MODE_UP,   0, 1, 0, 2'd0, 5);
        pushExp(MODE_HOLD, 1, 0, 1, 2'd0, 1);
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        idle(4);
        applyStimulus(0, 1, 1, 0, 2'd0, 7'd0);
        waitDrain();

        scenName = "empty_program";
        writeEntry(2'd0, 0, MODE_UP, 4'd1);
        pushExp(MODE_HOLD, 1, 0, 1, 2'd0, 1);
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        waitDrain();

        // A cfg write and a second start while busy must both be dropped.
        scenName = "busy_write";
        writeEntry(2'd0, 1, MODE_UP, 4'd1);
        writeEntry(2'd2, 0, MODE_UP, 4'd1);
        pushExp(MODE_UP,   0, 1, 0, 2'd0, 3);
        pushExp(MODE_HOLD, 1, 1, 0, 2'd0, 1);
        pushExp(MODE_DOWN, 0, 1, 0, 2'd1, 1);
        pushExp(MODE_HOLD, 1, 1, 0, 2'd1, 1);
        pushExp(MODE_HOLD, 1, 0, 1, 2'd1, 1);
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        applyStimulus(0, 0, 0, 1, 2'd1, {1'b1, MODE_UPDOWN, 4'd1});
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        idle(1);
        applyStimulus(0, 0, 1, 0, 2'd0, 7'd0);
        waitDrain();

        // Reset mid-program clears the table, so the next start finds entry 0 invalid.
        scenName = "mid_reset";
        pushExp(MODE_UP, 0, 1, 0, 2'd0, 2);
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        idle(2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pushExp(MODE_HOLD, 1, 0, 1, 2'd0, 1);
        applyStimulus(1, 0, 0, 0, 2'd0, 7'd0);
        waitDrain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
